bcd_multidigit_complementer: RTL

BCD_MULTIDIGIT_COMPLEMENTER -- requirements
Module: bcd_multidigit_complementer

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_comp.sv | 45 ++++
 rtl/bcd_multidigit_complementer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the multi-digit BCD complementer: FSM state type
// and BCD digit constants.
package bcd_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Bits per BCD digit
  localparam int BCD_DIGIT_W = 4;

endpackage : bcd_pkg

// File: rtl/bcd_digit_comp.sv
// Single-digit combinational BCD complement cell.
// Optional feature macro: BCD_COMP_ERR_CHECK_EN (flags digits above 9,
// forces them to 4'hF and lets the carry pass through untouched).
module bcd_digit_comp
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  input  logic                   cs,
  input  logic                   mode,
  input  logic                   cin,
  output logic [BCD_DIGIT_W-1:0] q,
  output logic                   cout,
  output logic                   bad
);

  logic [BCD_DIGIT_W-1:0] raw;
  logic [BCD_DIGIT_W:0]   sum;

  // Per-digit complement: pass-through, 9-d, or (9-d)+carry with decimal wrap
  always_comb begin
    raw  = BCD_MAX - d;
    sum  = {1'b0, raw} + {{BCD_DIGIT_W{1'b0}}, cin};
    q    = d;
    cout = 1'b0;
    bad  = 1'b0;
    if (cs) begin
      if (!mode) begin
        q = raw;
      end else if (sum == 5'd10) begin
        q    = '0;
        cout = 1'b1;
      end else begin
        q = sum[BCD_DIGIT_W-1:0];
      end
    end
`ifdef BCD_COMP_ERR_CHECK_EN
    if (d > BCD_MAX) begin
      bad  = 1'b1;
      q    = 4'hF;
      cout = cin;
    end
`endif
  end

endmodule : bcd_digit_comp

// File: rtl/bcd_multidigit_complementer.sv
// Serial multi-digit BCD 9's/10's complementer with valid/ready handshake.
// One digit is processed per cycle, LSD first, through a single digit cell.
// Optional feature macro: BCD_COMP_ERR_CHECK_EN (err reports digits above 9);
// without it the digit cell never flags, so err stays 0.
module bcd_multidigit_complementer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  input  logic                          cs,
  input  logic                          mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          cout,
  output logic                          err
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS);

  bcd_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     opnd_q;
  logic [W-1:0]     opnd_d;
  logic [W-1:0]     res_q;
  logic [W-1:0]     res_d;
  logic             carry_q;
  logic             err_acc_q;
  logic             cs_q;
  logic             mode_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [W-1:0]     bcd_out_q;
  logic             cout_q;
  logic             err_q;

  logic [BCD_DIGIT_W-1:0] dig_q;
  logic                   dig_cout;
  logic                   dig_bad;

  bcd_digit_comp u_digit (
    .d    (opnd_q[BCD_DIGIT_W-1:0]),
    .cs   (cs_q),
    .mode (mode_q),
    .cin  (carry_q),
    .q    (dig_q),
    .cout (dig_cout),
    .bad  (dig_bad)
  );

  // Operand shifts right so the next digit always sits in the low nibble
  assign opnd_d = opnd_q >> BCD_DIGIT_W;

  // Result digits enter at the top so the LSD ends up in bits [3:0]
  generate
    if (DIGITS == 1) begin : g_res_one
      assign res_d = dig_q;
    end else begin : g_res_many
      assign res_d = {dig_q, res_q[W-1:BCD_DIGIT_W]};
    end
  endgenerate

  // Control FSM with the datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      opnd_q      <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      err_acc_q   <= 1'b0;
      cs_q        <= 1'b0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_out_q   <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opnd_q     <= bcd_in;
            cs_q       <= cs;
            mode_q     <= mode;
            carry_q    <= cs & mode;
            idx_q      <= '0;
            res_q      <= '0;
            err_acc_q  <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // Index reaches DIGITS once every digit is done; it never wraps
          if (idx_q == IDX_LAST) begin
            bcd_out_q   <= res_q;
            cout_q      <= carry_q;
            err_q       <= err_acc_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            opnd_q    <= opnd_d;
            res_q     <= res_d;
            carry_q   <= dig_cout;
            err_acc_q <= err_acc_q | dig_bad;
            idx_q     <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_out_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule : bcd_multidigit_complementer
